// File: rtl/msdap_out_receiver.sv
// Host-side receiver for the MSDAP serial output: deserializes left/right words
// MSB-first and queues them in a show-ahead FIFO drained by valid/ready.
module msdap_out_receiver #(
   parameter int WIDTH      = 40,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 16
) (
   input  logic                          Sclk,
   input  logic                          Reset_n,
   input  logic                          Frame,
   input  logic                          OutReady,
   input  logic                          OutputL,
   input  logic                          OutputR,
   input  logic                          Clear_err,
   input  logic                          Word_ready,
   output logic                          Word_valid,
   output logic [WIDTH-1:0]              WordL,
   output logic [WIDTH-1:0]              WordR,
   output logic [$clog2(FIFO_DEPTH):0]   Fifo_count,
   output logic [CNT_W-1:0]              Word_count,
   output logic                          Frame_err,
   output logic                          Overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(WIDTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, SHIFT, PUSH} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] sh_l_q, sh_r_q;
   logic             start, capture, shift_en, push, err_set;

   logic [WIDTH-1:0] mem_l_q [FIFO_DEPTH];
   logic [WIDTH-1:0] mem_r_q [FIFO_DEPTH];
   logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
   logic [AW:0]      count_q, count_d;
   logic [WIDTH-1:0] head_l_q, head_l_d, head_r_q, head_r_d;
   logic [CNT_W-1:0] wc_q, wc_d;
   logic             ferr_q, ferr_d, ovf_q, ovf_d;
   logic             pop, full, wr_en, ovf_set;

   assign start = Frame & OutReady;

   always_ff @(posedge Sclk) begin
      if (!Reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (start) state_d = SHIFT;
         SHIFT: begin
            if (!OutReady)       state_d = IDLE;
            else if (Frame)      state_d = SHIFT;
            else if (cnt_q == 0) state_d = PUSH;
         end
         PUSH:    state_d = start ? SHIFT : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // A Frame inside a word flags an error but is still honoured as a new MSB.
   always_comb begin
      capture  = 1'b0;
      shift_en = 1'b0;
      push     = 1'b0;
      err_set  = 1'b0;
      case (state_q)
         IDLE:  capture = start;
         SHIFT: begin
            if (!OutReady) err_set = 1'b1;
            else if (Frame) begin
               err_set = 1'b1;
               capture = 1'b1;
            end else shift_en = 1'b1;
         end
         PUSH: begin
            push    = 1'b1;
            capture = start;
         end
         default: ;
      endcase
   end

   always_ff @(posedge Sclk) begin
      if (!Reset_n) begin
         sh_l_q <= '0;
         sh_r_q <= '0;
         cnt_q  <= '0;
      end else if (capture) begin
         sh_l_q <= {{(WIDTH-1){1'b0}}, OutputL};
         sh_r_q <= {{(WIDTH-1){1'b0}}, OutputR};
         cnt_q  <= CW'(WIDTH-2);
      end else if (shift_en) begin
         sh_l_q <= {sh_l_q[WIDTH-2:0], OutputL};
         sh_r_q <= {sh_r_q[WIDTH-2:0], OutputR};
         cnt_q  <= cnt_q - 1'b1;
      end
   end

   // When full, a simultaneous pop frees the slot the push lands in.
   always_comb begin
      pop     = (count_q != '0) & Word_ready;
      full    = (count_q == DEPTH_C);
      wr_en   = push & (~full | pop);
      ovf_set = push & full & ~pop;
      rd_d    = pop   ? rd_q + 1'b1 : rd_q;
      wr_d    = wr_en ? wr_q + 1'b1 : wr_q;
      case ({wr_en, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      head_l_d = head_l_q;
      head_r_d = head_r_q;
      if (count_d != '0) begin
         if (wr_en && (wr_q == rd_d)) begin
            head_l_d = sh_l_q;
            head_r_d = sh_r_q;
         end else begin
            head_l_d = mem_l_q[rd_d];
            head_r_d = mem_r_q[rd_d];
         end
      end
      wc_d   = push ? wc_q + 1'b1 : wc_q;
      ferr_d = err_set | (ferr_q & ~Clear_err);
      ovf_d  = ovf_set | (ovf_q & ~Clear_err);
   end

   always_ff @(posedge Sclk) begin
      if (wr_en) begin
         mem_l_q[wr_q] <= sh_l_q;
         mem_r_q[wr_q] <= sh_r_q;
      end
   end

   always_ff @(posedge Sclk) begin
      if (!Reset_n) begin
         rd_q     <= '0;
         wr_q     <= '0;
         count_q  <= '0;
         head_l_q <= '0;
         head_r_q <= '0;
         wc_q     <= '0;
         ferr_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         rd_q     <= rd_d;
         wr_q     <= wr_d;
         count_q  <= count_d;
         head_l_q <= head_l_d;
         head_r_q <= head_r_d;
         wc_q     <= wc_d;
         ferr_q   <= ferr_d;
         ovf_q    <= ovf_d;
      end
   end

   assign Word_valid = (count_q != '0);
   assign WordL      = head_l_q;
   assign WordR      = head_r_q;
   assign Fifo_count = count_q;
   assign Word_count = wc_q;
   assign Frame_err  = ferr_q;
   assign Overflow   = ovf_q;

endmodule

// File: tb/tb_msdap_out_receiver.sv
// Randomized bench for msdap_out_receiver: a queue-based reference model is
// stepped every edge and all outputs are compared every cycle.
module tb_msdap_out_receiver;
   localparam int W  = 40;
   localparam int D  = 4;
   localparam int CW = 16;

   logic Sclk = 1'b0;
   logic Reset_n, Frame, OutReady, OutputL, OutputR, Clear_err, Word_ready;
   logic Word_valid, Frame_err, Overflow;
   logic [W-1:0] WordL, WordR;
   logic [$clog2(D):0] Fifo_count;
   logic [CW-1:0] Word_count;

   msdap_out_receiver #(.WIDTH(W), .FIFO_DEPTH(D), .CNT_W(CW)) dut (
      .Sclk(Sclk), .Reset_n(Reset_n), .Frame(Frame), .OutReady(OutReady),
      .OutputL(OutputL), .OutputR(OutputR), .Clear_err(Clear_err),
      .Word_ready(Word_ready), .Word_valid(Word_valid), .WordL(WordL),
      .WordR(WordR), .Fifo_count(Fifo_count), .Word_count(Word_count),
      .Frame_err(Frame_err), .Overflow(Overflow));

   always #5 Sclk = ~Sclk;

   // reference model state
   logic [2*W-1:0] q[$];
   logic [W-1:0]   hl, hr, m_pl, m_pr, nx_l, nx_r;
   int             wc;
   bit             ferr, ovf, m_push, push_next, m_err;
   int             rdy_mode;
   bit             clr_pulse, clr_rand;
   int             n_cmp, n_bad;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] rnd40();
      return W'({$urandom, $urandom});
   endfunction

   function automatic void model_step();
      bit pop, ov;
      logic [2*W-1:0] h;
      if (!Reset_n) begin
         q.delete();
         hl = '0; hr = '0; wc = 0; ferr = 0; ovf = 0;
      end else begin
         pop = (q.size() > 0) && Word_ready;
         ov  = m_push && (q.size() == D) && !pop;
         if (pop) void'(q.pop_front());
         if (m_push) begin
            wc = (wc + 1) % (1 << CW);
            if (!ov) q.push_back({m_pl, m_pr});
         end
         ferr = m_err || (ferr && !Clear_err);
         ovf  = ov || (ovf && !Clear_err);
         if (q.size() > 0) begin
            h  = q[0];
            hl = h[2*W-1:W];
            hr = h[W-1:0];
         end
      end
   endfunction

   task automatic check_all();
      chk("valid",  64'(Word_valid), 64'(q.size() > 0));
      chk("wordL",  64'(WordL), 64'(hl));
      chk("wordR",  64'(WordR), 64'(hr));
      chk("count",  64'(Fifo_count), 64'(q.size()));
      chk("words",  64'(Word_count), 64'(wc));
      chk("ferr",   64'(Frame_err), 64'(ferr));
      chk("ovf",    64'(Overflow), 64'(ovf));
   endtask

   task automatic tick();
      Word_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
      Clear_err  = clr_pulse || (clr_rand && ($urandom_range(0, 15) == 0));
      @(posedge Sclk);
      model_step();
      m_push = push_next; m_pl = nx_l; m_pr = nx_r;
      push_next = 0; m_err = 0; clr_pulse = 0;
      @(negedge Sclk);
      check_all();
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         Frame = 1'($urandom_range(0, 1)); OutReady = 1'b0;
         OutputL = 1'($urandom_range(0, 1)); OutputR = 1'($urandom_range(0, 1));
         tick();
      end
   endtask

   // kind: 0 clean, 1 drop OutReady at bit cut, 2 stop before bit cut (restart), 3 reset at bit cut
   task automatic send_word(input logic [W-1:0] l, input logic [W-1:0] r,
                            input int cut, input int kind, input bit err_first);
      for (int i = 0; i < W; i++) begin
         if (kind == 2 && i == cut) return;
         if (kind == 1 && i == cut) begin
            Frame = 1'($urandom_range(0, 1)); OutReady = 1'b0;
            m_err = 1;
            tick();
            Frame = 1'b0;
            return;
         end
         Frame = (i == 0); OutReady = 1'b1;
         OutputL = l[W-1-i]; OutputR = r[W-1-i];
         if (i == 0 && err_first) m_err = 1;
         if (kind == 3 && i == cut) Reset_n = 1'b0;
         if (i == W-1) begin push_next = 1; nx_l = l; nx_r = r; end
         tick();
         if (kind == 3 && i == cut) begin
            Reset_n = 1'b1; OutReady = 1'b0; Frame = 1'b0;
            return;
         end
      end
   endtask

   task automatic drain();
      rdy_mode = 1; idle(D + 2); rdy_mode = 0;
   endtask

   initial begin
      int kind, cut;
      bit pend_err;
      n_cmp = 0; n_bad = 0;
      rdy_mode = 0; clr_pulse = 0; clr_rand = 0;
      push_next = 0; m_push = 0; m_err = 0;
      nx_l = '0; nx_r = '0; m_pl = '0; m_pr = '0;
      Reset_n = 1'b0; Frame = 1'b0; OutReady = 1'b0; OutputL = 1'b0; OutputR = 1'b0;
      Clear_err = 1'b0; Word_ready = 1'b0;
      tick(); tick();
      Reset_n = 1'b1;

      // single known word, then pop it
      send_word(40'h12_3456_789A, 40'hFF_FFFF_FFFF, 0, 0, 0);
      idle(3);
      drain();

      // five back-to-back words into a depth-4 FIFO
      for (int k = 0; k < 5; k++) send_word(rnd40(), rnd40(), 0, 0, 0);
      idle(2);
      drain();
      clr_pulse = 1; idle(1);

      // OutReady dropped after 20 bits, then a clean word
      send_word(rnd40(), rnd40(), 20, 1, 0);
      send_word(rnd40(), rnd40(), 0, 0, 0);
      idle(2);
      clr_pulse = 1; idle(1);
      drain();

      // Frame reasserted at bit 10
      send_word(rnd40(), rnd40(), 10, 2, 0);
      send_word(rnd40(), rnd40(), 0, 0, 1);
      idle(2);
      drain();
      clr_pulse = 1; idle(1);

      // full FIFO with a pop coinciding with the fifth push
      for (int k = 0; k < 5; k++) send_word(rnd40(), rnd40(), 0, 0, 0);
      rdy_mode = 1; idle(1); rdy_mode = 0;
      idle(2);
      drain();

      // reset mid-word, then a clean word
      send_word(rnd40(), rnd40(), 0, 0, 0);
      send_word(rnd40(), rnd40(), 25, 3, 0);
      idle(2);
      send_word(rnd40(), rnd40(), 0, 0, 0);
      idle(2);
      drain();

      // randomized traffic
      rdy_mode = 2; clr_rand = 1; pend_err = 0;
      for (int k = 0; k < 60; k++) begin
         kind = $urandom_range(0, 9);
         if (kind == 0) begin
            cut = $urandom_range(1, W-1);
            send_word(rnd40(), rnd40(), cut, 1, pend_err);
            pend_err = 0;
         end else if (kind == 1) begin
            cut = $urandom_range(1, W-2);
            send_word(rnd40(), rnd40(), cut, 2, pend_err);
            pend_err = 1;
         end else begin
            send_word(rnd40(), rnd40(), 0, 0, pend_err);
            pend_err = 0;
         end
         if (!pend_err && $urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      end
      if (pend_err) send_word(rnd40(), rnd40(), 0, 0, 1);
      clr_rand = 0;
      idle(2);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end
endmodule
